branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the FD stage of the 4-stage pipeline.
- Produces the 1-bit `jump` consumed by PC selection and learns from resolved branches reported by the X-stage branch checker.
- Holds a direct-mapped table of saturating counters indexed by PC, plus branch/mispredict statistics counters.

Parameters:
- IDX_BITS, 6, table index width; the table has 2**IDX_BITS entries.
- CTR_BITS, 2, saturating counter width; the MSB is the taken prediction.
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- pc_fd  in  32  PC of the instruction in FD.
- inst_fd  in  32  instruction in FD.
- jump  out  1  predict taken for the FD instruction.
- upd_valid  in  1  one-cycle pulse: a branch resolved in X.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_predict  in  1  prediction made for that branch (the pipelined `predict`).
- branch_cnt  out  STAT_BITS  number of resolved branches.
- mispredict_cnt  out  STAT_BITS  number of mispredicted branches.

Behaviour:
- Index is `pc[IDX_BITS+1:2]`. Lookup index comes from `pc_fd`; update index comes from `upd_pc`.
- Lookup is combinational, with zero latency.
  - `jump = (inst_fd[6:0] == OPC_BRANCH) & ctr[idx_fd][CTR_BITS-1]`.
  - `jump` is 0 for every non-branch opcode, including JAL and JALR.
- Update happens on the clock edge when `upd_valid` = 1.
  - If `upd_taken` = 1, the counter increments and saturates at all-ones.
  - If `upd_taken` = 0, the counter decrements and saturates at 0.
  - No wrap-around in either direction.
- Statistics on an `upd_valid` edge:
  - `branch_cnt` increments by 1.
  - `mispredict_cnt` increments by 1 when `upd_taken != upd_predict`.
  - Both statistics counters wrap modulo 2**STAT_BITS.
- Reset (rst = 0 at an edge):
  - Every counter is set to weakly-not-taken, i.e. value 2**(CTR_BITS-1) - 1, which is 01 for 2 bits.
  - `branch_cnt` = 0 and `mispredict_cnt` = 0.
  - `jump` reads 0 from the next cycle.
  - Reset takes priority over a simultaneous `upd_valid`; that update is dropped.
  - Reset asserted mid-operation discards all learned state.
- Read-during-write to the same index in the same cycle: `jump` reflects the pre-update counter value (no forwarding), unless the optional feature is compiled in.
- Aliasing: different PCs sharing an index share a counter. This is intended; there is no tag.
- Stall handling is the caller's responsibility. `upd_valid` must be pulsed exactly once per resolved branch, and each pulse is applied unconditionally. `jump` follows `pc_fd`/`inst_fd` combinationally, so a held FD stage yields a stable `jump`.
- `upd_valid` with `upd_pc` of a non-branch is still applied. Filtering is the caller's job.

Optional Feature:
- Macro: `BRANCH_PRED_BYPASS_EN`.
- Defined:
  - When `upd_valid` = 1 and the update index equals the lookup index, `jump` uses the post-update counter value in the same cycle.
  - Example: counter 01, update taken, same index gives `jump` = 1 this cycle.
- Undefined: no bypass path; behaviour as in Behaviour above.

Decomposition:
- Shared package / `Opcode.vh`:
  - `OPC_BRANCH` (reused).
  - New macros `BP_CTR_RESET` (weakly-not-taken) and `BP_IDX_LSB` = 2.
- Sub-module: `sat_counter`.
  - Pure combinational next-value function.
  - Inputs: current value, `taken`. Output: saturated next value. Parameterised by CTR_BITS.
  - Instantiated once on the update path, and once more for the bypass path under `BRANCH_PRED_BYPASS_EN`.
- Counter array and statistics registers stay in `branch_predictor`.

Test Plan:
1. Reset, then present `inst_fd` = BEQ (opcode 1100011), `pc_fd` = 0x100 -> `jump` = 0, `branch_cnt` = 0, `mispredict_cnt` = 0.
2. Two updates at `upd_pc` = 0x100, taken, `upd_predict` = 0 -> counter 01 -> 10 -> 11; FD at 0x100 with BEQ gives `jump` = 1; `branch_cnt` = 2, `mispredict_cnt` = 2.
3. Saturation:
   - Five taken updates at 0x104, then one not-taken -> counter 11, then 10; `jump` stays 1.
   - Three not-taken updates at 0x108 -> counter 00; `jump` = 0 with no wrap to 11.
4. Aliasing and opcode gating:
   - Train 0x100 to 11, then look up 0x200 (same index, IDX_BITS = 6) with BEQ -> `jump` = 1.
   - JAL opcode at 0x100 -> `jump` = 0.
5. Same-cycle conflicts:
   - Counter 01 at 0x100; update taken at 0x100 while FD = 0x100 -> `jump` = 0 that cycle without the macro, 1 with `BRANCH_PRED_BYPASS_EN`; 1 in the next cycle either way.
   - rst = 0 together with `upd_valid` -> update dropped; all counters 01.
6. Statistics wrap: with STAT_BITS = 4, 17 updates with `upd_taken != upd_predict` -> `branch_cnt` = 1, `mispredict_cnt` = 1.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared opcode constants and predictor table helpers.
package branch_predictor_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_ARI_I  = 7'b0010011,
        OPC_ARI_R  = 7'b0110011
    } opcode_e;

    // Instructions are word aligned, so the two low PC bits carry no index information.
    localparam int BP_IDX_LSB = 2;

    // Weakly-not-taken: MSB clear, every lower bit set.
    function automatic int bp_ctr_reset(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// FD lookup, X-stage update and statistics signals of the branch predictor.
interface branch_predictor_if #(
    parameter int STAT_BITS = 32
);
    logic [31:0]          pc_fd;
    logic [31:0]          inst_fd;
    logic                 jump;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic                 upd_taken;
    logic                 upd_predict;
    logic [STAT_BITS-1:0] branch_cnt;
    logic [STAT_BITS-1:0] mispredict_cnt;

    modport master (
        output pc_fd, inst_fd, upd_valid, upd_pc, upd_taken, upd_predict,
        input  jump, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_fd, inst_fd, upd_valid, upd_pc, upd_taken, upd_predict,
        output jump, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next value of a saturating up/down counter.
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: untagged direct-mapped table of saturating counters plus statistics.
// Defining BRANCH_PRED_BYPASS_EN forwards a same-index update into the lookup in the same cycle.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 6,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int                  NUM_ENT = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(bp_ctr_reset(CTR_BITS));

    logic [IDX_BITS-1:0]  idx_fd;
    logic [IDX_BITS-1:0]  idx_upd;
    logic [CTR_BITS-1:0]  ctr_q [NUM_ENT];
    logic [CTR_BITS-1:0]  ctr_fd;
    logic [CTR_BITS-1:0]  ctr_upd;
    logic [CTR_BITS-1:0]  ctr_upd_d;
    logic [CTR_BITS-1:0]  ctr_lookup;
    logic                 is_branch_fd;
    logic [STAT_BITS-1:0] branch_cnt_q;
    logic [STAT_BITS-1:0] branch_cnt_d;
    logic [STAT_BITS-1:0] mispredict_cnt_q;
    logic [STAT_BITS-1:0] mispredict_cnt_d;
    logic                 unused_bits;

    assign idx_fd  = bp.pc_fd[IDX_BITS+BP_IDX_LSB-1:BP_IDX_LSB];
    assign idx_upd = bp.upd_pc[IDX_BITS+BP_IDX_LSB-1:BP_IDX_LSB];
    assign ctr_fd  = ctr_q[idx_fd];
    assign ctr_upd = ctr_q[idx_upd];

    assign unused_bits = ^{bp.pc_fd[31:IDX_BITS+BP_IDX_LSB], bp.pc_fd[BP_IDX_LSB-1:0],
                           bp.upd_pc[31:IDX_BITS+BP_IDX_LSB], bp.upd_pc[BP_IDX_LSB-1:0],
                           bp.inst_fd[31:7]};

    sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_upd (
        .ctr_i   (ctr_upd),
        .taken_i (bp.upd_taken),
        .ctr_o   (ctr_upd_d)
    );

`ifdef BRANCH_PRED_BYPASS_EN
    logic [CTR_BITS-1:0] ctr_byp;

    sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_byp (
        .ctr_i   (ctr_fd),
        .taken_i (bp.upd_taken),
        .ctr_o   (ctr_byp)
    );

    assign ctr_lookup = (bp.upd_valid && (idx_upd == idx_fd)) ? ctr_byp : ctr_fd;
`else
    // Without the bypass a same-index update is seen by the lookup one cycle later.
    assign ctr_lookup = ctr_fd;
`endif

    // JAL/JALR are resolved elsewhere; only conditional branches are predicted.
    assign is_branch_fd = (bp.inst_fd[6:0] == OPC_BRANCH);
    assign bp.jump      = is_branch_fd & ctr_lookup[CTR_BITS-1];

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (bp.upd_valid) begin
            branch_cnt_d = branch_cnt_q + STAT_BITS'(1);
            if (bp.upd_taken != bp.upd_predict) begin
                mispredict_cnt_d = mispredict_cnt_q + STAT_BITS'(1);
            end
        end
    end

    // Reset wins over a coincident update, so that update is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else if (bp.upd_valid) begin
            ctr_q[idx_upd] <= ctr_upd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, corner sequences, random run against a model.
module tb_branch_predictor;

    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_JALR = 32'h00008067;
    localparam logic [31:0] I_ADD  = 32'h00208033;
    localparam logic [31:0] PC_IDL = 32'h00000010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.STAT_BITS(32)) bp ();
    branch_predictor_if #(.STAT_BITS(4))  bp4 ();

    branch_predictor #(.IDX_BITS(6), .CTR_BITS(2), .STAT_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    branch_predictor #(.IDX_BITS(6), .CTR_BITS(2), .STAT_BITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bp  (bp4)
    );

    int n_total = 0;
    int n_bad   = 0;

    int          mctr [64];
    logic [31:0] mbr;
    logic [31:0] mmis;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        up;
        logic        exp_jump;
        int          exp_br;
        int          exp_mis;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input logic t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic uv,
                                input logic [31:0] upc, input logic ut, input logic up,
                                input logic ej, input int br, input int mis);
        vec_t v;
        v.pc = pc; v.inst = inst; v.uv = uv; v.upc = upc; v.ut = ut; v.up = up;
        v.exp_jump = ej; v.exp_br = br; v.exp_mis = mis;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mctr[i] = 1;
        mbr  = '0;
        mmis = '0;
    endtask

    // Called just after a rising edge; drives, samples jump mid-cycle, crosses one edge.
    task automatic run_cycle(input logic [31:0] pc, input logic [31:0] inst, input logic uv,
                             input logic [31:0] upc, input logic ut, input logic up,
                             output logic js, output logic ej);
        int c;
        bp.pc_fd = pc; bp.inst_fd = inst; bp.upd_valid = uv;
        bp.upd_pc = upc; bp.upd_taken = ut; bp.upd_predict = up;
        #2;
        js = bp.jump;
        c = mctr[idx_of(pc)];
`ifdef BRANCH_PRED_BYPASS_EN
        if (uv && idx_of(upc) == idx_of(pc)) c = sat(c, ut);
`endif
        ej = (inst[6:0] == 7'b1100011) && (c >= 2);
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else if (uv) begin
            mctr[idx_of(upc)] = sat(mctr[idx_of(upc)], ut);
            mbr  = mbr + 1;
            if (ut != up) mmis = mmis + 1;
        end
        bp.upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        logic js, ej;
        rst = 1'b0;
        run_cycle(PC_IDL, I_ADD, 1'b0, '0, 1'b0, 1'b0, js, ej);
        rst = 1'b1;
    endtask

    initial begin
        logic js, ej;
        logic exp_rdw;

        bp.pc_fd = '0; bp.inst_fd = '0; bp.upd_valid = 1'b0;
        bp.upd_pc = '0; bp.upd_taken = 1'b0; bp.upd_predict = 1'b0;
        bp4.pc_fd = '0; bp4.inst_fd = '0; bp4.upd_valid = 1'b0;
        bp4.upd_pc = '0; bp4.upd_taken = 1'b0; bp4.upd_predict = 1'b0;
        model_reset();

        tbl[0]  = mk(32'h100, I_BEQ,  1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[1]  = mk(PC_IDL,  I_BEQ,  1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1, 1);
        tbl[2]  = mk(PC_IDL,  I_BEQ,  1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 2, 2);
        tbl[3]  = mk(32'h100, I_BEQ,  1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 2, 2);
        tbl[4]  = mk(32'h200, I_BEQ,  1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 2, 2);
        tbl[5]  = mk(32'h100, I_JAL,  1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 2, 2);
        tbl[6]  = mk(32'h100, I_JALR, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 2, 2);
        for (int i = 0; i < 5; i++)
            tbl[7+i] = mk(PC_IDL, I_BEQ, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 3 + i, 2);
        tbl[12] = mk(32'h104, I_BEQ,  1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 8, 3);
        tbl[13] = mk(32'h104, I_BEQ,  1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 8, 3);
        for (int i = 0; i < 3; i++)
            tbl[14+i] = mk(PC_IDL, I_BEQ, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 9 + i, 3);
        tbl[17] = mk(32'h108, I_BEQ,  1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 11, 3);
        tbl[18] = mk(PC_IDL,  I_BEQ,  1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 12, 4);
        tbl[19] = mk(32'h108, I_BEQ,  1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 12, 4);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_cycle(tbl[i].pc, tbl[i].inst, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].up, js, ej);
            check($sformatf("vec%0d_jump", i), 32'(js), 32'(tbl[i].exp_jump));
            check($sformatf("vec%0d_branch_cnt", i), bp.branch_cnt, 32'(tbl[i].exp_br));
            check($sformatf("vec%0d_mispredict_cnt", i), bp.mispredict_cnt, 32'(tbl[i].exp_mis));
        end

        do_reset();
        run_cycle(32'h100, I_BEQ, 1'b0, '0, 1'b0, 1'b0, js, ej);
        check("reset_jump", 32'(js), 32'd0);
`ifdef BRANCH_PRED_BYPASS_EN
        exp_rdw = 1'b1;
`else
        exp_rdw = 1'b0;
`endif
        run_cycle(32'h100, I_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, js, ej);
        check("rdw_same_cycle", 32'(js), 32'(exp_rdw));
        run_cycle(32'h100, I_BEQ, 1'b0, '0, 1'b0, 1'b0, js, ej);
        check("rdw_next_cycle", 32'(js), 32'd1);

        run_cycle(PC_IDL, I_BEQ, 1'b1, 32'h104, 1'b1, 1'b0, js, ej);
        rst = 1'b0;
        run_cycle(32'h100, I_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, js, ej);
        rst = 1'b1;
        check("rst_upd_branch_cnt", bp.branch_cnt, 32'd0);
        check("rst_upd_mispredict_cnt", bp.mispredict_cnt, 32'd0);
        run_cycle(32'h100, I_BEQ, 1'b0, '0, 1'b0, 1'b0, js, ej);
        check("rst_upd_dropped", 32'(js), 32'd0);
        run_cycle(32'h104, I_BEQ, 1'b0, '0, 1'b0, 1'b0, js, ej);
        check("rst_clears_0x104", 32'(js), 32'd0);
        run_cycle(PC_IDL, I_BEQ, 1'b1, 32'h100, 1'b1, 1'b1, js, ej);
        run_cycle(32'h100, I_BEQ, 1'b0, '0, 1'b0, 1'b0, js, ej);
        check("rst_value_weak_nt", 32'(js), 32'd1);

        bp4.upd_valid = 1'b1; bp4.upd_pc = 32'h100; bp4.upd_taken = 1'b1; bp4.upd_predict = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        bp4.upd_valid = 1'b0;
        check("stat4_branch_wrap", 32'(bp4.branch_cnt), 32'd1);
        check("stat4_mispredict_wrap", 32'(bp4.mispredict_cnt), 32'd1);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, inst, upc;
            logic        uv, ut, up;
            int          sel;
            pc  = 32'($urandom_range(0, 127)) << 2;
            upc = 32'($urandom_range(0, 127)) << 2;
            sel = $urandom_range(0, 3);
            inst = {$urandom} & 32'hFFFF_FF80;
            case (sel)
                0, 1: inst[6:0] = 7'b1100011;
                2:    inst[6:0] = 7'b1101111;
                default: inst[6:0] = 7'(($urandom_range(0, 1) != 0) ? 7'b1100111 : 7'b0110011);
            endcase
            uv = 1'($urandom_range(0, 1));
            ut = 1'($urandom_range(0, 1));
            up = 1'($urandom_range(0, 1));
            run_cycle(pc, inst, uv, upc, ut, up, js, ej);
            check($sformatf("rnd%0d_jump", i), 32'(js), 32'(ej));
            check($sformatf("rnd%0d_branch_cnt", i), bp.branch_cnt, mbr);
            check($sformatf("rnd%0d_mispredict_cnt", i), bp.mispredict_cnt, mmis);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
